// File: rtl/riscv_pkg.sv
// Shared RISC-V control definitions: FSM state encoding, ALUOp and memtoReg
// codes, opcode constants and the per-state control word.
// The single-cycle decoder imports the same ALUOp and opcode constants.
package riscv_pkg;

    // Opcode field values (instruction bits [6:0])
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUOp codes, shared with the single-cycle decoder
    localparam logic [1:0] ALUOP_R      = 2'b00;
    localparam logic [1:0] ALUOP_I      = 2'b01;
    localparam logic [1:0] ALUOP_ADD    = 2'b10;
    localparam logic [1:0] ALUOP_BRANCH = 2'b11;

    // Register write-back source select
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    typedef enum logic [3:0] {
        ST_INIT     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_ALU   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JAL      = 4'd11,
        ST_TRAP     = 4'd12
    } state_e;

    // Control word that depends on state alone
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_source;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    // Moore decode of the control word; anything not listed stays 0.
    // The mem_ready-qualified FETCH strobes and the branch pcWrite are
    // added by the controller because they also depend on inputs.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read = 1'b1;
                c.alu_op   = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                c.alu_src = 1'b0;
                c.alu_op  = ALUOP_R;
            end
            ST_EXEC_I: begin
                c.alu_src = 1'b1;
                c.alu_op  = ALUOP_I;
            end
            ST_MEM_ADDR: begin
                c.alu_src = 1'b1;
                c.alu_op  = ALUOP_ADD;
            end
            ST_MEM_RD: c.mem_read  = 1'b1;
            ST_MEM_WR: c.mem_write = 1'b1;
            ST_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_SEL_ALU;
            end
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_SEL_MEM;
            end
            ST_BRANCH: begin
                c.alu_src   = 1'b0;
                c.alu_op    = ALUOP_BRANCH;
                c.pc_source = 1'b1;
            end
            ST_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_SEL_PC4;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // States that wait on mem_ready and are guarded by the wait timer
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-cycle counter for memory accesses. 'expired' flags the
// wait cycle in which the count reaches MAX_WAIT, so the controller can
// trap on that same edge unless memory completes.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           inc,
    output logic                           expired,
    output logic [$clog2(MAX_WAIT+1)-1:0]  o_count
);

    localparam int         W     = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);
    localparam logic [W-1:0] LAST  = W'(MAX_WAIT - 1);

    logic [W-1:0] r_count;

    // Count wait cycles; clear wins, and the count holds at MAX_WAIT
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count < LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = inc && (r_count >= LAST);
    assign o_count = r_count;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller. A Moore FSM sequences fetch, decode,
// execute, memory and write-back; memory waits are bounded by a timer and
// illegal opcodes or stalled memory park the FSM in TRAP until reset.
//
// Memory handshake: in FETCH, MEM_RD and MEM_WR the controller holds its
// request strobe (memRead or memWrite) high every cycle; the access is
// complete in the cycle mem_ready is 1, and the FSM leaves the state on
// the following edge. mem_ready is ignored in every other state.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [6:0]                     opcode,
    input  logic                           br_taken,
    input  logic                           mem_ready,
    output logic                           pcWrite,
    output logic                           irWrite,
    output logic                           memRead,
    output logic                           memWrite,
    output logic                           regWrite,
    output logic                           pcSource,
    output logic                           ALUSrc,
    output logic [1:0]                     ALUOp,
    output logic [1:0]                     memtoReg,
    output logic                           illegal,
    output logic                           timeout,
    output state_e                         o_dbg_state,
    output logic [$clog2(MAX_WAIT+1)-1:0]  o_dbg_wait_cnt
);

    state_e r_state;
    state_e w_next;
    ctrl_t  r_ctrl;
    logic   r_illegal;
    logic   r_timeout;
    logic   r_is_store;

    logic   w_in_wait;
    logic   w_timer_clr;
    logic   w_timer_inc;
    logic   w_expired;
    logic   w_fetch_done;

    assign w_in_wait    = is_wait_state(r_state);
    // Clearing outside wait states and on completion gives a zero count on
    // every entry into FETCH, MEM_RD or MEM_WR.
    assign w_timer_clr  = !w_in_wait || mem_ready;
    assign w_timer_inc  = w_in_wait && !mem_ready;
    assign w_fetch_done = (r_state == ST_FETCH) && mem_ready;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_timer_clr),
        .inc      (w_timer_inc),
        .expired  (w_expired),
        .o_count  (o_dbg_wait_cnt)
    );

    // Next-state selection; completion beats expiry in a wait state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:   w_next = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)      w_next = ST_DECODE;
                else if (w_expired) w_next = ST_TRAP;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_R_TYPE:          w_next = ST_EXEC_R;
                    OP_I_TYPE:          w_next = ST_EXEC_I;
                    OP_LOAD, OP_STORE:  w_next = ST_MEM_ADDR;
                    OP_BRANCH:          w_next = ST_BRANCH;
                    OP_JAL:             w_next = ST_JAL;
                    default:            w_next = ST_TRAP;
                endcase
            end
            ST_EXEC_R:   w_next = ST_WB_ALU;
            ST_EXEC_I:   w_next = ST_WB_ALU;
            ST_MEM_ADDR: w_next = r_is_store ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready)      w_next = ST_WB_MEM;
                else if (w_expired) w_next = ST_TRAP;
            end
            ST_MEM_WR: begin
                if (mem_ready)      w_next = ST_FETCH;
                else if (w_expired) w_next = ST_TRAP;
            end
            ST_WB_ALU:   w_next = ST_FETCH;
            ST_WB_MEM:   w_next = ST_FETCH;
            ST_BRANCH:   w_next = ST_FETCH;
            ST_JAL:      w_next = ST_FETCH;
            ST_TRAP:     w_next = ST_TRAP;
            default:     w_next = ST_INIT;
        endcase
    end

    // State register, registered control word and sticky fault flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_ctrl     <= '0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next);
            // Remember load vs store so MEM_ADDR does not re-read opcode
            if (r_state == ST_DECODE) begin
                r_is_store <= (opcode == OP_STORE);
            end
            if ((r_state == ST_DECODE) && (w_next == ST_TRAP)) begin
                r_illegal <= 1'b1;
            end
            if (w_expired && !mem_ready) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign pcWrite     = r_ctrl.pc_write | w_fetch_done |
                         ((r_state == ST_BRANCH) && br_taken);
    assign irWrite     = r_ctrl.ir_write | w_fetch_done;
    assign memRead     = r_ctrl.mem_read;
    assign memWrite    = r_ctrl.mem_write;
    assign regWrite    = r_ctrl.reg_write;
    assign pcSource    = r_ctrl.pc_source;
    assign ALUSrc      = r_ctrl.alu_src;
    assign ALUOp       = r_ctrl.alu_op;
    assign memtoReg    = r_ctrl.mem_to_reg;
    assign illegal     = r_illegal;
    assign timeout     = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle controller outputs, the driver
// replays the matching inputs, and each test compares cycle by cycle.
module tb_multicycle_control;
    import riscv_pkg::*;

    localparam int MAX_WAIT = 15;
    localparam int CW       = $clog2(MAX_WAIT + 1);
    localparam int VW       = 17;

    // Strobe field order: pcWrite irWrite memRead memWrite regWrite pcSource ALUSrc
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_PCW  = 7'b1000000;
    localparam logic [6:0] S_IRW  = 7'b0100000;
    localparam logic [6:0] S_MRD  = 7'b0010000;
    localparam logic [6:0] S_MWR  = 7'b0001000;
    localparam logic [6:0] S_RW   = 7'b0000100;
    localparam logic [6:0] S_PCS  = 7'b0000010;
    localparam logic [6:0] S_ASRC = 7'b0000001;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst, br_taken, mem_ready;
    logic [6:0] opcode;
    logic pcWrite, irWrite, memRead, memWrite, regWrite, pcSource, ALUSrc;
    logic [1:0] ALUOp, memtoReg;
    logic illegal, timeout;
    state_e dbg_state;
    logic [CW-1:0] dbg_cnt;

    always #5 clk = ~clk;

    multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
        .pcWrite(pcWrite), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
        .regWrite(regWrite), .pcSource(pcSource), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .memtoReg(memtoReg), .illegal(illegal), .timeout(timeout),
        .o_dbg_state(dbg_state), .o_dbg_wait_cnt(dbg_cnt)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] obs_q[$];
    logic [9:0]    drv_q[$];   // {rst, opcode, mem_ready, br_taken}
    logic [CW-1:0] cnt_q[$];
    logic          m_il, m_to;
    logic [6:0]    m_op;

    // ---------------- reference model ----------------
    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [VW-1:0] ev(input state_e s, input logic [6:0] str,
                                         input logic [1:0] aop, input logic [1:0] m2r);
        return {s, str, aop, m2r, m_il, m_to};
    endfunction

    function automatic logic [3:0] st_of(input logic [VW-1:0] v);
        return v[16:13];
    endfunction

    task automatic push(input logic [VW-1:0] v, input logic r, input logic mr, input logic br);
        exp_q.push_back(v);
        drv_q.push_back({r, m_op, mr, br});
    endtask

    // Memory wait: 'waits' cycles with mem_ready low, then one ready cycle,
    // unless the MAX_WAIT-th low cycle is reached first (then timeout).
    task automatic add_wait(input state_e s, input logic [6:0] base_str, input logic [1:0] aop,
                            input logic [6:0] done_str, input int waits, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            if (i < waits) begin
                push(ev(s, base_str, aop, 2'b00), 1'b0, 1'b0, rbit());
                if (i + 1 == MAX_WAIT) begin
                    m_to = 1'b1;
                    return;
                end
            end else begin
                push(ev(s, done_str, aop, 2'b00), 1'b0, 1'b1, rbit());
                ok = 1'b1;
            end
        end
    endtask

    task automatic add_trap(input int n);
        repeat (n) push(ev(ST_TRAP, S_NONE, 2'b00, 2'b00), 1'b0, rbit(), rbit());
    endtask

    // One instruction from FETCH entry to its last state
    task automatic add_instr(input logic [6:0] op, input logic br, input int fw, input int mw);
        bit ok;
        m_op = op;
        add_wait(ST_FETCH, S_MRD, ALUOP_ADD, S_MRD | S_IRW | S_PCW, fw, ok);
        if (!ok) begin
            add_trap(3);
            return;
        end
        push(ev(ST_DECODE, S_NONE, 2'b00, 2'b00), 1'b0, rbit(), rbit());
        case (op)
            OP_R_TYPE: begin
                push(ev(ST_EXEC_R, S_NONE, ALUOP_R, 2'b00), 1'b0, rbit(), rbit());
                push(ev(ST_WB_ALU, S_RW, 2'b00, WB_SEL_ALU), 1'b0, rbit(), rbit());
            end
            OP_I_TYPE: begin
                push(ev(ST_EXEC_I, S_ASRC, ALUOP_I, 2'b00), 1'b0, rbit(), rbit());
                push(ev(ST_WB_ALU, S_RW, 2'b00, WB_SEL_ALU), 1'b0, rbit(), rbit());
            end
            OP_LOAD: begin
                push(ev(ST_MEM_ADDR, S_ASRC, ALUOP_ADD, 2'b00), 1'b0, rbit(), rbit());
                add_wait(ST_MEM_RD, S_MRD, 2'b00, S_MRD, mw, ok);
                if (ok) push(ev(ST_WB_MEM, S_RW, 2'b00, WB_SEL_MEM), 1'b0, rbit(), rbit());
                else    add_trap(3);
            end
            OP_STORE: begin
                push(ev(ST_MEM_ADDR, S_ASRC, ALUOP_ADD, 2'b00), 1'b0, rbit(), rbit());
                add_wait(ST_MEM_WR, S_MWR, 2'b00, S_MWR, mw, ok);
                if (!ok) add_trap(3);
            end
            OP_BRANCH: begin
                push(ev(ST_BRANCH, S_PCS | (br ? S_PCW : S_NONE), ALUOP_BRANCH, 2'b00),
                     1'b0, rbit(), br);
            end
            OP_JAL: begin
                push(ev(ST_JAL, S_PCW | S_PCS | S_RW, 2'b00, WB_SEL_PC4), 1'b0, rbit(), rbit());
            end
            default: begin
                m_il = 1'b1;
                add_trap(3);
            end
        endcase
    endtask

    // First cycle of the following fetch, still waiting on memory
    task automatic add_tail();
        m_op = OP_R_TYPE;
        push(ev(ST_FETCH, S_MRD, ALUOP_ADD, 2'b00), 1'b0, 1'b0, rbit());
    endtask

    // ---------------- driver ----------------
    task automatic apply_reset();
        rst       = 1'b1;
        opcode    = 7'($urandom);
        mem_ready = rbit();
        br_taken  = rbit();
        @(posedge clk); #1;
        rst  = 1'b0;
        m_il = 1'b0;
        m_to = 1'b0;
        m_op = 7'($urandom);
        exp_q.delete();
        drv_q.delete();
        push(ev(ST_INIT, S_NONE, 2'b00, 2'b00), 1'b0, rbit(), rbit());
    endtask

    task automatic play();
        logic [9:0] d;
        obs_q.delete();
        cnt_q.delete();
        while (drv_q.size() > 0) begin
            d = drv_q.pop_front();
            {rst, opcode, mem_ready, br_taken} = d;
            @(negedge clk);
            obs_q.push_back({dbg_state, pcWrite, irWrite, memRead, memWrite, regWrite,
                             pcSource, ALUSrc, ALUOp, memtoReg, illegal, timeout});
            cnt_q.push_back(dbg_cnt);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [VW-1:0] obs, expv;
        m_il = 1'b0;
        m_to = 1'b0;
        expv = ev(ST_INIT, S_NONE, 2'b00, 2'b00);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            opcode    = 7'($urandom);
            mem_ready = rbit();
            br_taken  = rbit();
            @(negedge clk);
            obs = {dbg_state, pcWrite, irWrite, memRead, memWrite, regWrite,
                   pcSource, ALUSrc, ALUOp, memtoReg, illegal, timeout};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL reset_outputs cyc%0d got=%h exp=%h", i, obs, expv);
            end
            checks++;
            if (dbg_cnt !== '0) begin
                failures++;
                $display("FAIL reset_counter cyc%0d got=%0d exp=0", i, dbg_cnt);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        int first_f, next_f;
        apply_reset();
        add_instr(OP_R_TYPE, 1'b0, 0, 0);
        add_tail();
        play();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rtype cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        first_f = -1;
        next_f  = -1;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (st_of(obs_q[i]) == ST_FETCH) begin
                if (first_f < 0) first_f = i;
                else if (next_f < 0 && st_of(obs_q[i-1]) != ST_FETCH) next_f = i;
            end
        end
        checks++;
        if (next_f - first_f != 4) begin
            failures++;
            $display("FAIL rtype_latency got=%0d exp=4", next_f - first_f);
        end
    endtask

    task automatic test_load_wait();
        int first_f, next_f, rd_cycles;
        apply_reset();
        add_instr(OP_LOAD, 1'b0, 0, 3);
        add_tail();
        play();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL load_wait cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        first_f   = -1;
        next_f    = -1;
        rd_cycles = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (st_of(obs_q[i]) == ST_MEM_RD) rd_cycles++;
            if (st_of(obs_q[i]) == ST_FETCH) begin
                if (first_f < 0) first_f = i;
                else if (next_f < 0 && st_of(obs_q[i-1]) != ST_FETCH) next_f = i;
            end
        end
        checks++;
        if (rd_cycles != 4) begin
            failures++;
            $display("FAIL load_memrd_hold got=%0d exp=4", rd_cycles);
        end
        checks++;
        if (next_f - first_f != 8) begin
            failures++;
            $display("FAIL load_latency got=%0d exp=8", next_f - first_f);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        add_instr(OP_BRANCH, 1'b0, 0, 0);
        add_instr(OP_BRANCH, 1'b1, 1, 0);
        add_instr(OP_JAL, 1'b0, 0, 0);
        add_tail();
        play();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL branch_jal cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [VW-1:0] obs, expv;
        apply_reset();
        add_instr(7'b1111111, 1'b0, 0, 0);
        add_trap(17);
        play();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL illegal_trap cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        m_il = 1'b0;
        m_to = 1'b0;
        expv = ev(ST_INIT, S_NONE, 2'b00, 2'b00);
        @(negedge clk);
        obs = {dbg_state, pcWrite, irWrite, memRead, memWrite, regWrite,
               pcSource, ALUSrc, ALUOp, memtoReg, illegal, timeout};
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL illegal_cleared got=%h exp=%h", obs, expv);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int wr_cycles;
        // Store stalls forever: trap after MAX_WAIT write wait cycles
        apply_reset();
        add_instr(OP_STORE, 1'b0, 0, MAX_WAIT + 5);
        play();
        wr_cycles = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (st_of(obs_q[i]) == ST_MEM_WR) wr_cycles++;
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL store_timeout cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (wr_cycles != MAX_WAIT) begin
            failures++;
            $display("FAIL store_timeout_waits got=%0d exp=%0d", wr_cycles, MAX_WAIT);
        end
        // Ready arrives on the last allowed cycle: normal completion
        apply_reset();
        add_instr(OP_STORE, 1'b0, 0, MAX_WAIT - 1);
        add_tail();
        play();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL store_last_ready cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        // Instruction fetch that never completes
        apply_reset();
        add_instr(OP_R_TYPE, 1'b0, MAX_WAIT + 2, 0);
        play();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL fetch_timeout cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        m_op = OP_LOAD;
        push(ev(ST_FETCH, S_MRD | S_IRW | S_PCW, ALUOP_ADD, 2'b00), 1'b0, 1'b1, rbit());
        push(ev(ST_DECODE, S_NONE, 2'b00, 2'b00), 1'b0, rbit(), rbit());
        push(ev(ST_MEM_ADDR, S_ASRC, ALUOP_ADD, 2'b00), 1'b0, rbit(), rbit());
        push(ev(ST_MEM_RD, S_MRD, 2'b00, 2'b00), 1'b0, 1'b0, rbit());
        push(ev(ST_MEM_RD, S_MRD, 2'b00, 2'b00), 1'b1, 1'b0, rbit());
        push(ev(ST_INIT, S_NONE, 2'b00, 2'b00), 1'b0, rbit(), rbit());
        push(ev(ST_FETCH, S_MRD, ALUOP_ADD, 2'b00), 1'b0, 1'b0, rbit());
        play();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL reset_mid_wait cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (cnt_q[5] !== CW'(1)) begin
            failures++;
            $display("FAIL mid_wait_count got=%0d exp=1", cnt_q[5]);
        end
        checks++;
        if (cnt_q[6] !== '0) begin
            failures++;
            $display("FAIL post_reset_count got=%0d exp=0", cnt_q[6]);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[6];
        ops[0] = OP_R_TYPE; ops[1] = OP_I_TYPE; ops[2] = OP_LOAD;
        ops[3] = OP_STORE;  ops[4] = OP_BRANCH; ops[5] = OP_JAL;
        for (int round = 0; round < 3; round++) begin
            apply_reset();
            for (int n = 0; n < 30; n++) begin
                add_instr(ops[$urandom_range(0, 5)], rbit(),
                          $urandom_range(0, 3), $urandom_range(0, 5));
            end
            add_tail();
            play();
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random r%0d cyc%0d got=%h exp=%h", round, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        opcode    = '0;
        mem_ready = 1'b0;
        br_taken  = 1'b0;
        m_il      = 1'b0;
        m_to      = 1'b0;
        m_op      = '0;
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
